// File: rtl/rs_int_scheduler_if.sv
// Dispatch/issue/status bundle between the integer RS scheduler and its neighbours.
// master = scheduler side, slave = dispatch stage, RS lines and FU side.
interface rs_int_scheduler_if #(
    parameter int unsigned LINE_NUM        = 8,
    parameter int unsigned LINE_ADDR_WIDTH = 3
);
    logic                       flush;
    logic                       dispatch_valid;
    logic                       dispatch_ready;
    logic [LINE_NUM-1:0]        write_en;
    logic [LINE_NUM-1:0]        line_ready;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [LINE_ADDR_WIDTH-1:0] issue_sel;
    logic [LINE_NUM-1:0]        issue_en;
    logic [LINE_NUM-1:0]        busy;
    logic [LINE_ADDR_WIDTH:0]   free_count;

    modport master (
        input  flush, dispatch_valid, line_ready, issue_ready,
        output dispatch_ready, write_en, issue_valid, issue_sel, issue_en, busy, free_count
    );

    modport slave (
        output flush, dispatch_valid, line_ready, issue_ready,
        input  dispatch_ready, write_en, issue_valid, issue_sel, issue_en, busy, free_count
    );
endinterface

// File: rtl/rs_int_scheduler.sv
// Integer RS allocation/issue scheduler: lowest-free allocation, one issue per cycle.
// Define RS_AGE_ORDER_EN for oldest-first issue via an age matrix; default is lowest-index issue.
module rs_int_scheduler #(
    parameter int unsigned LINE_NUM        = 8,
    parameter int unsigned LINE_ADDR_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    rs_int_scheduler_if.master bus
);

    localparam int unsigned CNT_W = LINE_ADDR_WIDTH + 1;

    logic [LINE_NUM-1:0]        busy_q, busy_d;
    logic [LINE_NUM-1:0]        cand;
    logic [LINE_ADDR_WIDTH-1:0] alloc_idx;
    logic                       alloc_hit;
    logic [LINE_ADDR_WIDTH-1:0] sel_idx;
    logic                       sel_hit;
    logic [CNT_W-1:0]           free_cnt;
    logic                       dispatch_fire;
    logic                       issue_fire;

    assign cand = busy_q & bus.line_ready;

    always_comb begin
        alloc_idx = '0;
        alloc_hit = 1'b0;
        free_cnt  = CNT_W'(LINE_NUM);
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            free_cnt = free_cnt - CNT_W'(busy_q[i]);
            if (!alloc_hit && !busy_q[i]) begin
                alloc_idx = LINE_ADDR_WIDTH'(i);
                alloc_hit = 1'b1;
            end
        end
    end

    assign bus.dispatch_ready = (free_cnt != '0) && !bus.flush;
    assign dispatch_fire      = bus.dispatch_valid && bus.dispatch_ready;
    assign bus.issue_valid    = (|cand) && !bus.flush;
    assign issue_fire         = bus.issue_valid && bus.issue_ready;
    assign bus.issue_sel      = sel_idx;
    assign bus.busy           = busy_q;
    assign bus.free_count     = free_cnt;

    always_comb begin
        bus.write_en = '0;
        bus.issue_en = '0;
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            bus.write_en[i] = dispatch_fire && (alloc_idx == LINE_ADDR_WIDTH'(i));
            bus.issue_en[i] = issue_fire && (sel_idx == LINE_ADDR_WIDTH'(i));
        end
    end

    // Write and issue strobes never target the same line: one hits a free line, the other a busy one.
    always_comb begin
        busy_d = (busy_q | bus.write_en) & ~bus.issue_en;
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

`ifdef RS_AGE_ORDER_EN
    // older_q[i][j] set means line j was allocated before line i; stale bits of freed lines are masked by cand.
    logic [LINE_NUM-1:0] older_q [LINE_NUM];
    logic [LINE_NUM-1:0] older_d [LINE_NUM];

    always_comb begin
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            older_d[i] = older_q[i];
        end
        if (dispatch_fire) begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                older_d[i][alloc_idx] = 1'b0;
            end
            older_d[alloc_idx] = busy_q;
        end
        if (bus.flush) begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                older_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            if (!sel_hit && cand[i] && ((older_q[i] & cand) == '0)) begin
                sel_idx = LINE_ADDR_WIDTH'(i);
                sel_hit = 1'b1;
            end
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        for (int unsigned i = 0; i < LINE_NUM; i++) begin
            if (!sel_hit && cand[i]) begin
                sel_idx = LINE_ADDR_WIDTH'(i);
                sel_hit = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_int_scheduler.sv
// Randomized self-checking bench for rs_int_scheduler against a queue-based reference model.
// Follows RS_AGE_ORDER_EN for the expected issue policy.
module tb_rs_int_scheduler;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs_int_scheduler_if #(.LINE_NUM(N), .LINE_ADDR_WIDTH(3)) bus ();

    rs_int_scheduler #(.LINE_NUM(N), .LINE_ADDR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which lines hold an instruction, and their allocation order (oldest first).
    bit m_busy [N];
    int age_q [$];
    logic [2:0] obs_sel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input logic r, input logic fl, input logic dv,
                        input logic [N-1:0] lr, input logic ir);
        int free_n;
        int k;
        int sel;
        logic dr;
        logic iv;
        logic [N-1:0] we;
        logic [N-1:0] ie;
        logic [N-1:0] bv;
        rst = r;
        bus.flush = fl;
        bus.dispatch_valid = dv;
        bus.line_ready = lr;
        bus.issue_ready = ir;
        #4;
        obs_sel = bus.issue_sel;
        free_n = 0;
        k = -1;
        bv = '0;
        for (int i = 0; i < N; i++) begin
            bv[i] = m_busy[i];
            if (!m_busy[i]) begin
                free_n++;
                if (k < 0) k = i;
            end
        end
        dr = (free_n != 0) && !fl;
        we = '0;
        if (dv && dr) we[k] = 1'b1;
        sel = -1;
`ifdef RS_AGE_ORDER_EN
        foreach (age_q[q]) if (sel < 0 && lr[age_q[q]]) sel = age_q[q];
`else
        for (int i = 0; i < N; i++) if (sel < 0 && m_busy[i] && lr[i]) sel = i;
`endif
        iv = (sel >= 0) && !fl;
        if (sel < 0) sel = 0;
        ie = '0;
        if (iv && ir) ie[sel] = 1'b1;
        // First reset cycle mid-operation still shows the pre-reset lines; checked from the next cycle on.
        if (r || bv == '0) begin
            check_eq("busy", 32'(bus.busy), 32'(bv));
            check_eq("free_count", 32'(bus.free_count), 32'(free_n));
            check_eq("dispatch_ready", 32'(bus.dispatch_ready), 32'(dr));
            check_eq("write_en", 32'(bus.write_en), 32'(we));
            check_eq("issue_valid", 32'(bus.issue_valid), 32'(iv));
            check_eq("issue_sel", 32'(bus.issue_sel), 32'(sel));
            check_eq("issue_en", 32'(bus.issue_en), 32'(ie));
        end
        if (!r || fl) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            age_q.delete();
        end else begin
            if (ie != '0) begin
                m_busy[sel] = 1'b0;
                for (int q = 0; q < age_q.size(); q++) begin
                    if (age_q[q] == sel) begin
                        age_q.delete(q);
                        break;
                    end
                end
            end
            if (we != '0) begin
                m_busy[k] = 1'b1;
                age_q.push_back(k);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sel [3];
`ifdef RS_AGE_ORDER_EN
        exp_sel = '{2, 0, 1};
`else
        exp_sel = '{0, 1, 2};
`endif
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.line_ready = '0;
        bus.issue_ready = 1'b0;
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check_eq("idle_free", 32'(bus.free_count), 32'd8);
        check_eq("idle_busy", 32'(bus.busy), 32'h00);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("full_busy", 32'(bus.busy), 32'hFF);
        check_eq("full_free", 32'(bus.free_count), 32'd0);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("ninth_ignored", 32'(bus.busy), 32'hFF);

        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
        check_eq("reuse_not_same_cycle", 32'(bus.busy), 32'h1D);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("reuse_next_cycle", 32'(bus.busy), 32'h1F);

        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h03, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h03, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h07, 1'b1);
            check_eq("age_order_sel", 32'(obs_sel), 32'(exp_sel[i]));
        end

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("pre_flush_busy", 32'(bus.busy), 32'h0F);
        step(1'b1, 1'b1, 1'b1, 8'h0F, 1'b1);
        check_eq("flush_busy", 32'(bus.busy), 32'h00);
        check_eq("flush_free", 32'(bus.free_count), 32'd8);

        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
        check_eq("stall_busy", 32'(bus.busy), 32'h01);
        step(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);

        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(19) == 0),
                 ($urandom_range(9) < 7),
                 N'($urandom),
                 ($urandom_range(9) < 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
